pwm_timebase_loader: RTL

- Upstream stage for the I/Q PWM comparator.
- Generates the free-running timebase `tb` and presents double-buffered compare words `cmpH`/`cmpL` to the comparator.
- New duty words arrive from the control side through a valid/ready handshake.
- Words are applied only at a period boundary, so the comparator never sees a mid-frame compare change.

---
 rtl/pwm_timebase_loader.sv | 119 +++++++++++
 1 files changed

// File: rtl/pwm_timebase_loader.sv
// Free-running PWM timebase with double-buffered compare/period words.
// Control-side words are held in a one-entry buffer and become active only at a period wrap.
module pwm_timebase_loader #(
    parameter int unsigned         WIDTH      = 17,
    parameter logic [WIDTH-1:0]    RST_PERIOD = WIDTH'(2**WIDTH - 1),
    parameter logic [WIDTH-1:0]    RST_HALF   = WIDTH'(2**(WIDTH - 1))
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_cmpH,
    input  logic [WIDTH:0]   in_cmpL,
    input  logic [WIDTH-1:0] in_period,
    output logic [WIDTH-1:0] tb,
    output logic [WIDTH-1:0] cmpH,
    output logic [WIDTH:0]   cmpL,
    output logic             frame,
    output logic             range_err
);

    logic [WIDTH-1:0] tb_q, tb_d;
    logic [WIDTH-1:0] cmpH_q, cmpH_d;
    logic [WIDTH:0]   cmpL_q, cmpL_d;
    logic [WIDTH-1:0] periodAct_q, periodAct_d;

    logic [WIDTH-1:0] pendH_q, pendH_d;
    logic [WIDTH:0]   pendL_q, pendL_d;
    logic [WIDTH-1:0] pendP_q, pendP_d;
    logic             pendFull_q, pendFull_d;

    logic             ready_q, ready_d;
    logic             frame_q, frame_d;
    logic             rangeErr_q, rangeErr_d;

    logic             wrap;
    logic             accept;
    logic             inRange;

    assign wrap    = en && (tb_q == periodAct_q);
    assign accept  = in_valid && ready_q;
    assign inRange = (in_cmpH <= in_period) && (in_cmpL[WIDTH:1] <= in_period);

    always_comb begin
        tb_d        = tb_q;
        cmpH_d      = cmpH_q;
        cmpL_d      = cmpL_q;
        periodAct_d = periodAct_q;
        pendH_d     = pendH_q;
        pendL_d     = pendL_q;
        pendP_d     = pendP_q;
        pendFull_d  = pendFull_q;
        frame_d     = 1'b0;
        rangeErr_d  = 1'b0;

        if (en) begin
            tb_d    = wrap ? '0 : tb_q + 1'b1;
            frame_d = wrap;
        end

        // A word accepted on the wrap edge with an empty buffer skips the buffer entirely.
        if (wrap && pendFull_q) begin
            cmpH_d      = pendH_q;
            cmpL_d      = pendL_q;
            periodAct_d = pendP_q;
            pendFull_d  = 1'b0;
        end else if (accept && !inRange) begin
            rangeErr_d = 1'b1;
        end else if (accept && wrap) begin
            cmpH_d      = in_cmpH;
            cmpL_d      = in_cmpL;
            periodAct_d = in_period;
        end else if (accept) begin
            pendH_d    = in_cmpH;
            pendL_d    = in_cmpL;
            pendP_d    = in_period;
            pendFull_d = 1'b1;
        end

        ready_d = !pendFull_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tb_q        <= '0;
            cmpH_q      <= '0;
            cmpL_q      <= {RST_HALF, 1'b0};
            periodAct_q <= RST_PERIOD;
            pendH_q     <= '0;
            pendL_q     <= '0;
            pendP_q     <= '0;
            pendFull_q  <= 1'b0;
            ready_q     <= 1'b1;
            frame_q     <= 1'b0;
            rangeErr_q  <= 1'b0;
        end else begin
            tb_q        <= tb_d;
            cmpH_q      <= cmpH_d;
            cmpL_q      <= cmpL_d;
            periodAct_q <= periodAct_d;
            pendH_q     <= pendH_d;
            pendL_q     <= pendL_d;
            pendP_q     <= pendP_d;
            pendFull_q  <= pendFull_d;
            ready_q     <= ready_d;
            frame_q     <= frame_d;
            rangeErr_q  <= rangeErr_d;
        end
    end

    assign in_ready  = ready_q;
    assign tb        = tb_q;
    assign cmpH      = cmpH_q;
    assign cmpL      = cmpL_q;
    assign frame     = frame_q;
    assign range_err = rangeErr_q;

endmodule
